// File: rtl/waveform_sequencer.sv
// waveform_sequencer: Wishbone-programmable table of (frequency, amplitude,
// duration) segments that steps a signal_generator through them in order,
// optionally looping, with a done flag and level interrupt on completion.
module waveform_sequencer #(
   parameter int NSEG   = 8,
   parameter int FREQ_W = 24
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_ni,
   input  logic              wbs_cyc_i,
   input  logic              wbs_stb_i,
   input  logic              wbs_we_i,
   input  logic [31:0]       wbs_adr_i,
   input  logic [31:0]       wbs_dat_i,
   input  logic [3:0]        wbs_sel_i,
   output logic              wbs_ack_o,
   output logic [31:0]       wbs_dat_o,
   output logic [FREQ_W-1:0] sg_freq_o,
   output logic [7:0]        sg_amp_o,
   output logic              sg_load_o,
   input  logic              sg_ready_i,
   output logic              sg_en_o,
   output logic              irq_o
);

   localparam int IDX_W = $clog2(NSEG);

   localparam logic [5:0] A_CTRL     = 6'h00;
   localparam logic [5:0] A_STATUS   = 6'h01;
   localparam logic [5:0] A_PRESCALE = 6'h02;

   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;

   // Bus-side registers
   logic              ack_q;
   logic [31:0]       dat_q;
   logic              loop_q, irq_en_q;
   logic [IDX_W-1:0]  last_q;
   logic [15:0]       presc_q;
   logic [FREQ_W-1:0] seg_freq_q [NSEG];
   logic [7:0]        seg_amp_q  [NSEG];
   logic [15:0]       seg_dur_q  [NSEG];

   // Sequencer registers
   state_e            state_q;
   logic [IDX_W-1:0]  idx_q;
   logic              done_q, load_q, en_q;
   logic [FREQ_W-1:0] freq_q;
   logic [7:0]        amp_q;
   logic [15:0]       dur_cnt_q, pcnt_q, presc_act_q;

   // Decode and next-state helpers
   logic [5:0]        word_a;
   logic              bus_req, wr_req, rd_req, seg_hit;
   logic [IDX_W-1:0]  seg_a, nxt_idx_d;
   logic              start_w, stop_w, clr_done_w, tick;
   logic [31:0]       freq_old, cfg_old, ctrl_rd, status_rd, rdata_d;
   logic [31:0]       freq_wr, cfg_wr, ctrl_wr, presc_wr;

   // Byte-lane merge of write data over the current register contents
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) begin
         r[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
      end
      return r;
   endfunction

   // A request is serviced only in the cycle it is first seen (ack low),
   // which also forces the mandatory gap between consecutive acks.
   assign word_a  = wbs_adr_i[7:2];
   assign bus_req = wbs_cyc_i & wbs_stb_i & ~ack_q;
   assign wr_req  = bus_req & wbs_we_i;
   assign rd_req  = bus_req & ~wbs_we_i;
   assign seg_a   = word_a[1 +: IDX_W];
   assign seg_hit = (word_a[5:4] == 2'b01) && ((word_a[3:1] >> IDX_W) == 3'd0);

   assign tick      = (state_q == RUN) && (pcnt_q == presc_act_q);
   assign nxt_idx_d = (idx_q < last_q) ? idx_q + IDX_W'(1) : '0;

   // Current register images used for readback and for byte-merged writes
   // NOTE: every always_comb target gets a default first so no latch can be inferred.
   always_comb begin
      freq_old               = '0;
      freq_old[FREQ_W-1:0]   = seg_freq_q[seg_a];
      cfg_old                = {8'h00, seg_amp_q[seg_a], seg_dur_q[seg_a]};
      ctrl_rd                = '0;
      ctrl_rd[2]             = loop_q;
      ctrl_rd[3]             = irq_en_q;
      ctrl_rd[4 +: IDX_W]    = last_q;
      status_rd              = '0;
      status_rd[0]           = (state_q != IDLE);
      status_rd[1]           = done_q;
      status_rd[4 +: IDX_W]  = idx_q;
   end

   assign freq_wr  = merge_bytes(freq_old, wbs_dat_i, wbs_sel_i);
   assign cfg_wr   = merge_bytes(cfg_old, wbs_dat_i, wbs_sel_i);
   assign ctrl_wr  = merge_bytes(ctrl_rd, wbs_dat_i, wbs_sel_i);
   assign presc_wr = merge_bytes({16'h0000, presc_q}, wbs_dat_i, wbs_sel_i);

   // start/stop read back as 0, so the merged image carries exactly the written pulses
   assign start_w    = wr_req && (word_a == A_CTRL) && ctrl_wr[0];
   assign stop_w     = wr_req && (word_a == A_CTRL) && ctrl_wr[1];
   assign clr_done_w = wr_req && (word_a == A_STATUS) && wbs_sel_i[0] && wbs_dat_i[1];

   // Read data mux; unmapped words read 0
   always_comb begin
      rdata_d = '0;
      if (word_a == A_CTRL)          rdata_d = ctrl_rd;
      else if (word_a == A_STATUS)   rdata_d = status_rd;
      else if (word_a == A_PRESCALE) rdata_d = {16'h0000, presc_q};
      else if (seg_hit)              rdata_d = word_a[0] ? cfg_old : freq_old;
   end

   // Wishbone handshake: one-cycle ack per request, read data registered alongside it
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         ack_q <= 1'b0;
         dat_q <= '0;
      end else begin
         ack_q <= bus_req;
         dat_q <= rd_req ? rdata_d : '0;
      end
   end

   // Configuration registers and segment table written from the bus
   // NOTE: the segment table lives in flops rather than RAM so reset can clear it.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         loop_q   <= 1'b0;
         irq_en_q <= 1'b0;
         last_q   <= '0;
         presc_q  <= '0;
         for (int i = 0; i < NSEG; i++) begin
            seg_freq_q[i] <= '0;
            seg_amp_q[i]  <= '0;
            seg_dur_q[i]  <= '0;
         end
      end else if (wr_req) begin
         if (word_a == A_CTRL) begin
            loop_q   <= ctrl_wr[2];
            irq_en_q <= ctrl_wr[3];
            last_q   <= ctrl_wr[4 +: IDX_W];
         end
         if (word_a == A_PRESCALE) presc_q <= presc_wr[15:0];
         if (seg_hit) begin
            if (word_a[0]) begin
               seg_amp_q[seg_a] <= cfg_wr[23:16];
               seg_dur_q[seg_a] <= cfg_wr[15:0];
            end else begin
               seg_freq_q[seg_a] <= freq_wr[FREQ_W-1:0];
            end
         end
      end
   end

   // Sequencer FSM: walks the segments and drives the signal_generator handshake
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         done_q      <= 1'b0;
         load_q      <= 1'b0;
         en_q        <= 1'b0;
         freq_q      <= '0;
         amp_q       <= '0;
         dur_cnt_q   <= '0;
         pcnt_q      <= '0;
         presc_act_q <= '0;
      end else begin
         // NOTE: non-blocking updates let the completion path below override this
         // clear, so a done set in the same cycle as a W1C survives.
         if (clr_done_w) done_q <= 1'b0;
         if (stop_w) begin
            state_q <= IDLE;
            load_q  <= 1'b0;
            en_q    <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start_w) begin
                     state_q <= LOAD;
                     idx_q   <= '0;
                     done_q  <= 1'b0;
                     load_q  <= 1'b1;
                     en_q    <= 1'b1;
                     freq_q  <= seg_freq_q[0];
                     amp_q   <= seg_amp_q[0];
                  end
               end
               LOAD: begin
                  if (sg_ready_i) begin
                     state_q     <= RUN;
                     load_q      <= 1'b0;
                     dur_cnt_q   <= (seg_dur_q[idx_q] == 16'd0) ? 16'd1 : seg_dur_q[idx_q];
                     pcnt_q      <= '0;
                     presc_act_q <= presc_q;
                  end
               end
               RUN: begin
                  if (tick) begin
                     // A new PRESCALE value is adopted only on a tick boundary
                     pcnt_q      <= '0;
                     presc_act_q <= presc_q;
                     if (dur_cnt_q > 16'd1) begin
                        dur_cnt_q <= dur_cnt_q - 16'd1;
                     end else if ((idx_q < last_q) || loop_q) begin
                        state_q <= LOAD;
                        idx_q   <= nxt_idx_d;
                        load_q  <= 1'b1;
                        freq_q  <= seg_freq_q[nxt_idx_d];
                        amp_q   <= seg_amp_q[nxt_idx_d];
                     end else begin
                        state_q <= IDLE;
                        en_q    <= 1'b0;
                        done_q  <= 1'b1;
                     end
                  end else begin
                     pcnt_q <= pcnt_q + 16'd1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;
   assign sg_freq_o = freq_q;
   assign sg_amp_o  = amp_q;
   assign sg_load_o = load_q;
   assign sg_en_o   = en_q;
   assign irq_o     = done_q & irq_en_q;

   // Address and merge bits that carry no state in this register map
   logic unused_ok;
   assign unused_ok = ^{wbs_adr_i[31:8], wbs_adr_i[1:0], freq_wr, cfg_wr[31:24],
                        presc_wr[31:16], ctrl_wr};

endmodule

// File: tb/tb_waveform_sequencer.sv
// Testbench for waveform_sequencer: directed scenarios plus randomized
// segment programs, checked against a segment-level reference model.
`timescale 1ns/1ps
module tb_waveform_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [31:0] adr = '0, wdat = '0;
   logic [3:0]  sel = '0;
   logic        ack;
   logic [31:0] rdat;
   logic [23:0] freq;
   logic [7:0]  amp;
   logic        load, en, irq;
   logic        ready = 1'b0;

   always #5 clk = ~clk;

   waveform_sequencer #(.NSEG(8), .FREQ_W(24)) dut (
      .wb_clk_i  (clk),
      .wb_rst_ni (rst_n),
      .wbs_cyc_i (cyc),
      .wbs_stb_i (stb),
      .wbs_we_i  (we),
      .wbs_adr_i (adr),
      .wbs_dat_i (wdat),
      .wbs_sel_i (sel),
      .wbs_ack_o (ack),
      .wbs_dat_o (rdat),
      .sg_freq_o (freq),
      .sg_amp_o  (amp),
      .sg_load_o (load),
      .sg_ready_i(ready),
      .sg_en_o   (en),
      .irq_o     (irq)
   );

   // Reference model: segment table contents and prescale as programmed
   logic [23:0] m_freq [8];
   logic [7:0]  m_amp  [8];
   logic [15:0] m_dur  [8];
   int          m_presc = 0;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Cycles a segment spends in RUN: one tick per PRESCALE+1 cycles, duration 0 acts as 1
   function automatic int run_len(input int i);
      return (m_presc + 1) * ((m_dur[i] == 16'd0) ? 1 : int'(m_dur[i]));
   endfunction

   task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] r);
      int guard;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!ack && guard < 16);
      if (!ack) check("ack_timeout", 32'(ack), 32'd1);
      r = rdat;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
      logic [31:0] dummy;
      wb_xfer(1'b1, a, d, s, dummy);
   endtask

   task automatic wb_read(input logic [31:0] a, output logic [31:0] r);
      wb_xfer(1'b0, a, 32'h0, 4'hF, r);
   endtask

   task automatic program_seg(input int i, input logic [23:0] f, input logic [7:0] a,
                              input logic [15:0] d);
      wb_write(32'h40 + 32'(8 * i), {8'h00, f});
      wb_write(32'h44 + 32'(8 * i), {8'h00, a, d});
      m_freq[i] = f; m_amp[i] = a; m_dur[i] = d;
   endtask

   task automatic set_presc(input int p);
      wb_write(32'h08, 32'(p));
      m_presc = p;
   endtask

   // Follow n_visits segment visits in order 0..last(,0..); delay<0 picks a random ready delay
   task automatic run_visits(input int n_visits, input int last, input int delay);
      int idx, dly, cnt, guard;
      bit held;
      idx = 0;
      for (int v = 0; v < n_visits; v++) begin
         guard = 0;
         while (!load && guard < 64) begin
            @(negedge clk);
            guard++;
         end
         if (!load) begin
            check("load_timeout", 32'(load), 32'd1);
            return;
         end
         check("seg_freq", 32'(freq), 32'(m_freq[idx]));
         check("seg_amp", 32'(amp), 32'(m_amp[idx]));
         dly  = (delay < 0) ? int'($urandom_range(0, 4)) : delay;
         held = 1'b1;
         for (int c = 0; c < dly; c++) begin
            ready = 1'b0;
            @(negedge clk);
            if (!load || !en || freq !== m_freq[idx] || amp !== m_amp[idx]) held = 1'b0;
         end
         check("load_held", 32'(held), 32'd1);
         ready = 1'b1;
         @(negedge clk);
         ready = 1'b0;
         check("load_drop", {load, en}, 2'b01);
         cnt = 0;
         while (en && !load && cnt < 4096) begin
            cnt++;
            @(negedge clk);
         end
         check("run_len", cnt, run_len(idx));
         idx = (idx >= last) ? 0 : idx + 1;
      end
   endtask

   initial begin
      logic [31:0] r;
      int          last, irq_en;
      bit          seen;

      // Reset state
      #12;
      check("rst_freq", 32'(freq), 32'h0);
      check("rst_outs", {ack, load, en, irq, amp}, 32'h0);
      check("rst_dat", rdat, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      wb_read(32'h00, r); check("rst_ctrl", r, 32'h0);
      wb_read(32'h04, r); check("rst_status", r, 32'h0);
      wb_read(32'h08, r); check("rst_presc", r, 32'h0);
      wb_read(32'h5C, r); check("rst_seg3_cfg", r, 32'h0);

      // Byte selects, register widths, unmapped space, stop beating start
      wb_write(32'h40, 32'hAABBCCDD, 4'b0101);
      wb_read(32'h40, r); check("bytesel_freq", r, 32'h00BB00DD);
      wb_write(32'h08, 32'h12345678);
      wb_read(32'h08, r); check("presc_width", r, 32'h00005678);
      wb_write(32'h0C, 32'hFFFFFFFF);
      wb_read(32'h0C, r); check("unmapped_0c", r, 32'h0);
      wb_read(32'h80, r); check("unmapped_80", r, 32'h0);
      wb_write(32'h00, 32'h00000003);
      check("stop_wins_en", 32'(en), 32'h0);
      wb_read(32'h00, r); check("ctrl_pulses_read0", r, 32'h0);

      // Single segment, PRESCALE 1, duration 3 -> 6 RUN cycles then done
      set_presc(1);
      program_seg(0, 24'h001000, 8'h80, 16'd3);
      wb_write(32'h00, 32'h00000001);
      run_visits(1, 0, 0);
      check("single_en_off", {load, en}, 2'b00);
      wb_read(32'h04, r); check("single_status", r, 32'h00000002);

      // Three segments looping, ready held low 5 cycles each, then stop
      set_presc(int'($urandom_range(0, 2)));
      for (int i = 0; i < 3; i++)
         program_seg(i, 24'h010000 * 24'(i + 1) + 24'($urandom_range(0, 255)),
                     8'(8'h10 + i), 16'(1 + $urandom_range(0, 2)));
      wb_write(32'h00, 32'h00000025);
      run_visits(3, 2, 5);
      begin
         int guard = 0;
         while (!load && guard < 64) begin
            @(negedge clk);
            guard++;
         end
      end
      check("wrap_freq", 32'(freq), 32'(m_freq[0]));
      seen = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (!load || freq !== m_freq[0]) seen = 1'b0;
      end
      check("wrap_held", 32'(seen), 32'd1);
      wb_write(32'h00, 32'h00000026);
      check("stop_outs", {load, en}, 2'b00);
      wb_read(32'h04, r); check("stop_status", r, 32'h0);

      // Duration 0 with PRESCALE 0 -> one RUN cycle per segment
      set_presc(0);
      for (int i = 0; i < 3; i++)
         program_seg(i, 24'($urandom()), 8'($urandom()), 16'd0);
      wb_write(32'h00, 32'h00000021);
      run_visits(3, 2, -1);
      wb_read(32'h04, r); check("dur0_status", r, 32'h00000022);

      // Interrupt: enable with done pending, clear, then completion colliding with W1C
      wb_write(32'h00, 32'h00000028);
      check("irq_set", 32'(irq), 32'd1);
      wb_write(32'h04, 32'h00000002);
      check("irq_clr", 32'(irq), 32'd0);
      wb_read(32'h04, r); check("w1c_status", r, 32'h00000020);
      program_seg(0, 24'h0000AA, 8'h55, 16'd1);
      ready = 1'b1;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h00; wdat = 32'h00000009; sel = 4'hF;
      @(negedge clk);
      check("race_start_ack", 32'(ack), 32'd1);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(negedge clk);
      check("race_in_run", {load, en}, 2'b01);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h04; wdat = 32'h00000002;
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0; we = 1'b0; ready = 1'b0;
      check("race_en_off", 32'(en), 32'd0);
      check("race_irq", 32'(irq), 32'd1);
      wb_read(32'h04, r); check("race_done_kept", r, 32'h00000002);
      wb_write(32'h04, 32'h00000002);

      // Randomized programs against the model
      for (int it = 0; it < 6; it++) begin
         last   = int'($urandom_range(0, 7));
         irq_en = int'($urandom_range(0, 1));
         set_presc(int'($urandom_range(0, 3)));
         for (int i = 0; i <= last; i++)
            program_seg(i, 24'($urandom()), 8'($urandom()), 16'($urandom_range(0, 4)));
         wb_write(32'h00, 32'(1 | (irq_en << 3) | (last << 4)));
         run_visits(last + 1, last, -1);
         check("rand_en_off", {load, en}, 2'b00);
         check("rand_irq", 32'(irq), 32'(irq_en));
         wb_read(32'h04, r); check("rand_status", r, 32'(2 | (last << 4)));
      end

      // Reset mid-RUN: outputs drop immediately, nothing restarts afterwards
      set_presc(3);
      program_seg(0, 24'h123456, 8'hC3, 16'd200);
      ready = 1'b1;
      wb_write(32'h00, 32'h00000009);
      repeat (10) @(negedge clk);
      check("pre_rst_run", {load, en}, 2'b01);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_freq", 32'(freq), 32'h0);
      check("async_rst_outs", {ack, load, en, irq, amp}, 32'h0);
      ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wb_read(32'h04, r); check("post_rst_status", r, 32'h0);
      wb_read(32'h44, r); check("post_rst_seg0", r, 32'h0);
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (load || en) seen = 1'b1;
      end
      check("no_restart", 32'(seen), 32'd0);

      // Back-to-back reads: ack one cycle wide with a gap cycle between
      wb_write(32'h00, 32'h0000000C);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h00; sel = 4'hF;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("b2b_ack", 32'(ack), (c % 2 == 0) ? 32'd1 : 32'd0);
         if (c % 2 == 0) check("b2b_dat", rdat, 32'h0000000C);
      end
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/waveform_sequencer.md
WAVEFORM_SEQUENCER -- requirements
Module: waveform_sequencer

Interface
REQ-001 SHALL have parameter NSEG, default 8, number of segment-table entries (power of 2, 2..8).
REQ-002 SHALL have parameter FREQ_W, default 24, width of the frequency tuning word.
REQ-003 SHALL have port wb_clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port wb_rst_ni, input, 1, reset; asynchronous assertion, active-low.
REQ-005 SHALL have ports wbs_cyc_i, wbs_stb_i, wbs_we_i, input, 1 each, Wishbone classic slave controls.
REQ-006 SHALL have ports wbs_adr_i [31:0], wbs_dat_i [31:0] and wbs_sel_i [3:0], inputs, Wishbone address, write data and byte selects.
REQ-007 SHALL have port wbs_ack_o, output, 1, Wishbone acknowledge.
REQ-008 SHALL have port wbs_dat_o, output, 32, Wishbone read data.
REQ-009 SHALL have ports sg_freq_o [FREQ_W-1:0] and sg_amp_o [7:0], outputs, tuning word and amplitude presented to signal_generator.
REQ-010 SHALL have port sg_load_o, output, 1, request that signal_generator accept sg_freq_o/sg_amp_o.
REQ-011 SHALL have port sg_ready_i, input, 1, signal_generator acceptance of the current load.
REQ-012 SHALL have port sg_en_o, output, 1, signal_generator output enable.
REQ-013 SHALL have port irq_o, output, 1, level interrupt driven while STATUS.done is set and CTRL.irq_en is set.

Function
REQ-014 SHALL decode wbs_adr_i[7:2] only: 0x00 CTRL, 0x04 STATUS, 0x08 PRESCALE[15:0], 0x40+8*i SEGi_FREQ, 0x44+8*i SEGi_CFG (amp [23:16], duration [15:0]); unmapped reads return 0, unmapped writes ignored.
REQ-015 SHALL assert wbs_ack_o for exactly one cycle, the cycle after wbs_cyc_i&wbs_stb_i is first seen; it SHALL deassert for at least one cycle between acks.
REQ-016 SHALL honour wbs_sel_i per byte on writes; reads return full words.
REQ-017 CTRL layout: bit0 start (write-1 pulse, reads 0), bit1 stop (write-1 pulse, reads 0), bit2 loop, bit3 irq_en, bits[6:4] last segment index (masked to log2(NSEG) bits).
REQ-018 STATUS layout: bit0 busy (state != IDLE), bit1 done (write-1-to-clear), bits[6:4] current segment index; other bits read 0.
REQ-019 SHALL implement states IDLE, LOAD and RUN.
REQ-020 IDLE: on start, go to LOAD with idx=0 and clear done; sg_en_o=0, sg_load_o=0.
REQ-021 LOAD: drive sg_freq_o/sg_amp_o from segment idx and hold sg_load_o=1 until sg_ready_i=1.
REQ-022 LOAD exit: in the cycle sg_ready_i=1, sg_load_o SHALL drop next cycle and the block SHALL enter RUN with dur_cnt=duration and the prescaler cleared.
REQ-023 Prescaler SHALL generate a tick every PRESCALE+1 cycles while in RUN.
REQ-024 RUN: each tick decrements dur_cnt; duration 0 SHALL behave as 1.
REQ-025 RUN, on the tick where dur_cnt reaches 0: if idx<last, go to LOAD with idx+1.
REQ-026 RUN, on the tick where dur_cnt reaches 0 with idx==last: if loop=1, go to LOAD with idx=0; otherwise go to IDLE and set done.
REQ-027 sg_en_o SHALL be 1 in LOAD and RUN and 0 in IDLE; sg_freq_o/sg_amp_o SHALL hold their last values in IDLE.
REQ-028 Stop SHALL force IDLE on the next edge from any state, with sg_load_o=0, sg_en_o=0 and done not set.
REQ-029 If stop and start are written together, stop SHALL win; start while busy SHALL be ignored.
REQ-030 Segment writes while busy SHALL be accepted and take effect at that segment's next LOAD; a PRESCALE write SHALL take effect at the next tick boundary.
REQ-031 If done is set by the sequencer and cleared by a W1C write in the same cycle, set SHALL win.

Reset
REQ-032 While wb_rst_ni=0: state IDLE, idx 0, all CTRL/STATUS/PRESCALE bits 0, wbs_ack_o=0, wbs_dat_o=0, sg_load_o=0, sg_en_o=0, sg_freq_o=0, sg_amp_o=0, irq_o=0; segment table cleared to 0.
REQ-033 Reset assertion mid-sequence SHALL abort immediately with no further sg_load_o pulses after release until a new start.

Verification
REQ-034 Program SEG0 freq 0x001000, amp 0x80, dur 3; PRESCALE 1; last=0; start -> sg_load_o high with 0x001000/0x80; hold sg_ready_i 1 -> RUN lasts 6 cycles -> IDLE, done=1, sg_en_o=0.
REQ-035 Program 3 segments, last=2, loop=1; hold sg_ready_i low 5 cycles at each LOAD -> sg_load_o held steady, segments visited in order 0,1,2,0; write stop -> IDLE next cycle, done=0.
REQ-036 Program duration 0, PRESCALE 0 -> RUN lasts exactly 1 cycle per segment.
REQ-037 Set irq_en, run to completion -> irq_o=1; W1C done -> irq_o=0; simultaneous completion and W1C -> done stays 1.
REQ-038 Pull wb_rst_ni low mid-RUN -> all outputs 0 asynchronously, STATUS reads 0 after release; back-to-back Wishbone reads -> each ack one cycle wide with a gap cycle.
